// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types, constants and tag helper for the branch predictor
package bpu_pkg;
    localparam int DEF_INDEX_BITS = 4;
    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_t;
    localparam cnt_t CNT_ALLOC = WT;
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        cnt_t        cnt;
    } btb_entry_t;
    function automatic logic [29:0] tag_of(input logic [31:0] pc, input int index_bits);
        return 30'(pc >> (index_bits + 2));
    endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup and execute resolution signals of the predictor
interface branch_predictor_if #(parameter int CNT_WIDTH = 16);
    logic [31:0]          PCF;
    logic                 PredTakenF;
    logic [31:0]          PredNextF;
    logic                 BranchE;
    logic                 TakenE;
    logic [31:0]          PCE;
    logic [31:0]          TargetE;
    logic [31:0]          PredNextE;
    logic                 StallE;
    logic                 FlushE;
    logic                 MispredictE;
    logic [31:0]          RecoverPCE;
    logic [CNT_WIDTH-1:0] BranchCount;
    logic [CNT_WIDTH-1:0] MispredCount;
    modport master (
        output PCF, BranchE, TakenE, PCE, TargetE, PredNextE, StallE, FlushE,
        input  PredTakenF, PredNextF, MispredictE, RecoverPCE, BranchCount, MispredCount
    );
    modport slave (
        input  PCF, BranchE, TakenE, PCE, TargetE, PredNextE, StallE, FlushE,
        output PredTakenF, PredNextF, MispredictE, RecoverPCE, BranchCount, MispredCount
    );
endinterface

// File: rtl/sat_counter2.sv
// sat_counter2: 2-bit saturating direction counter next state
module sat_counter2
    import bpu_pkg::*;
(
    input  cnt_t cnt,
    input  logic taken,
    output cnt_t nxt
);
    always_comb
        nxt = taken ? (cnt == ST ? ST : cnt_t'(cnt + 2'd1))
                    : (cnt == SNT ? SNT : cnt_t'(cnt - 2'd1));
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, mispredict detection and perf counters
module branch_predictor
    import bpu_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int CNT_WIDTH  = 16
) (
    input logic clk,
    input logic rst,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 2 ** INDEX_BITS;
    btb_entry_t tbl_q [ENTRIES];
    btb_entry_t tbl_d [ENTRIES];
    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;
    logic [INDEX_BITS-1:0] idx_f, idx_e;
    logic hit_f, hit_e, upd, mispredict;
    logic [31:0] actual_next;
    cnt_t cnt_nxt;
    assign idx_f = bp.PCF[INDEX_BITS+1:2];
    assign idx_e = bp.PCE[INDEX_BITS+1:2];
    sat_counter2 u_sat (.cnt(tbl_q[idx_e].cnt), .taken(bp.TakenE), .nxt(cnt_nxt));
    always_comb begin
        hit_f = tbl_q[idx_f].valid && tbl_q[idx_f].tag == tag_of(bp.PCF, INDEX_BITS);
        hit_e = tbl_q[idx_e].valid && tbl_q[idx_e].tag == tag_of(bp.PCE, INDEX_BITS);
        upd = bp.BranchE && !bp.StallE && !bp.FlushE;
        actual_next = bp.TakenE ? bp.TargetE : bp.PCE + 32'd4;
        mispredict = upd && bp.PredNextE != actual_next;
        bp.PredTakenF = hit_f && tbl_q[idx_f].cnt[1];
        bp.PredNextF = bp.PredTakenF ? tbl_q[idx_f].target : bp.PCF + 32'd4;
        bp.MispredictE = mispredict;
        bp.RecoverPCE = actual_next;
        bp.BranchCount = branch_cnt_q;
        bp.MispredCount = mispred_cnt_q;
        branch_cnt_d = (upd && !(&branch_cnt_q)) ? branch_cnt_q + 1'b1 : branch_cnt_q;
        mispred_cnt_d = (mispredict && !(&mispred_cnt_q)) ? mispred_cnt_q + 1'b1 : mispred_cnt_q;
        tbl_d = tbl_q;
        // a taken miss steals the slot even if another branch aliases into it
        if (upd && hit_e) begin
            tbl_d[idx_e].cnt = cnt_nxt;
            if (bp.TakenE)
                tbl_d[idx_e].target = bp.TargetE;
        end else if (upd && bp.TakenE) begin
            tbl_d[idx_e] = '{valid: 1'b1, tag: tag_of(bp.PCE, INDEX_BITS), target: bp.TargetE, cnt: CNT_ALLOC};
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WNT};
            branch_cnt_q <= '0;
            mispred_cnt_q <= '0;
        end else begin
            tbl_q <= tbl_d;
            branch_cnt_q <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table plus saturation and mid-run reset sequences
module tb_branch_predictor;
    typedef struct {
        logic [31:0] pcf;
        logic        br, tk;
        logic [31:0] pce, tgt, pne;
        logic        st, fl;
        logic        ept;
        logic [31:0] epn;
        logic        emp;
        logic [31:0] erc;
        logic [15:0] ebc, emc;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs [18];
    branch_predictor_if #(.CNT_WIDTH(16)) bif ();
    branch_predictor #(.INDEX_BITS(4), .CNT_WIDTH(16)) dut (.clk(clk), .rst(rst), .bp(bif));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic drive(input logic [31:0] pcf, input logic br, input logic tk, input logic [31:0] pce,
                         input logic [31:0] tgt, input logic [31:0] pne, input logic st, input logic fl);
        bif.PCF = pcf;
        bif.BranchE = br;
        bif.TakenE = tk;
        bif.PCE = pce;
        bif.TargetE = tgt;
        bif.PredNextE = pne;
        bif.StallE = st;
        bif.FlushE = fl;
    endtask
    initial begin
        vecs[0]  = '{'h100, 1'b0, 1'b0, 'h0, 'h0, 'h0, 1'b0, 1'b0, 1'b0, 'h104, 1'b0, 'h4, 16'd0, 16'd0};
        vecs[1]  = '{'h100, 1'b1, 1'b1, 'h100, 'h80, 'h104, 1'b0, 1'b0, 1'b0, 'h104, 1'b1, 'h80, 16'd0, 16'd0};
        vecs[2]  = '{'h100, 1'b1, 1'b0, 'h100, 'h80, 'h80, 1'b0, 1'b0, 1'b1, 'h80, 1'b1, 'h104, 16'd1, 16'd1};
        vecs[3]  = '{'h100, 1'b1, 1'b0, 'h100, 'h80, 'h104, 1'b0, 1'b0, 1'b0, 'h104, 1'b0, 'h104, 16'd2, 16'd2};
        vecs[4]  = '{'h100, 1'b1, 1'b1, 'h100, 'h80, 'h104, 1'b0, 1'b0, 1'b0, 'h104, 1'b1, 'h80, 16'd3, 16'd2};
        vecs[5]  = '{'h100, 1'b1, 1'b1, 'h100, 'h80, 'h104, 1'b0, 1'b0, 1'b0, 'h104, 1'b1, 'h80, 16'd4, 16'd3};
        vecs[6]  = '{'h100, 1'b0, 1'b0, 'h0, 'h0, 'h0, 1'b0, 1'b0, 1'b1, 'h80, 1'b0, 'h4, 16'd5, 16'd4};
        vecs[7]  = '{'h140, 1'b1, 1'b1, 'h140, 'h200, 'h144, 1'b0, 1'b0, 1'b0, 'h144, 1'b1, 'h200, 16'd5, 16'd4};
        vecs[8]  = '{'h100, 1'b0, 1'b0, 'h0, 'h0, 'h0, 1'b0, 1'b0, 1'b0, 'h104, 1'b0, 'h4, 16'd6, 16'd5};
        vecs[9]  = '{'h140, 1'b1, 1'b1, 'h140, 'h300, 'h200, 1'b0, 1'b0, 1'b1, 'h200, 1'b1, 'h300, 16'd6, 16'd5};
        vecs[10] = '{'h140, 1'b0, 1'b0, 'h0, 'h0, 'h0, 1'b0, 1'b0, 1'b1, 'h300, 1'b0, 'h4, 16'd7, 16'd6};
        vecs[11] = '{'h140, 1'b1, 1'b0, 'h140, 'h0, 'h300, 1'b1, 1'b0, 1'b1, 'h300, 1'b0, 'h144, 16'd7, 16'd6};
        vecs[12] = '{'h140, 1'b1, 1'b0, 'h140, 'h0, 'h300, 1'b0, 1'b1, 1'b1, 'h300, 1'b0, 'h144, 16'd7, 16'd6};
        vecs[13] = '{'h140, 1'b0, 1'b0, 'h0, 'h0, 'h0, 1'b0, 1'b0, 1'b1, 'h300, 1'b0, 'h4, 16'd7, 16'd6};
        vecs[14] = '{'h140, 1'b1, 1'b1, 'h140, 'h300, 'h300, 1'b0, 1'b0, 1'b1, 'h300, 1'b0, 'h300, 16'd7, 16'd6};
        vecs[15] = '{'hFFFFFFFC, 1'b0, 1'b0, 'h0, 'h0, 'h0, 1'b0, 1'b0, 1'b0, 'h0, 1'b0, 'h4, 16'd8, 16'd6};
        vecs[16] = '{'h140, 1'b1, 1'b0, 'hFFFFFFFC, 'h0, 'h0, 1'b0, 1'b0, 1'b1, 'h300, 1'b0, 'h0, 16'd8, 16'd6};
        vecs[17] = '{'hFFFFFFFC, 1'b0, 1'b0, 'h0, 'h0, 'h0, 1'b0, 1'b0, 1'b0, 'h0, 1'b0, 'h4, 16'd9, 16'd6};
        drive('h0, 1'b0, 1'b0, 'h0, 'h0, 'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].pcf, vecs[i].br, vecs[i].tk, vecs[i].pce, vecs[i].tgt, vecs[i].pne, vecs[i].st, vecs[i].fl);
            @(negedge clk);
            chk($sformatf("v%0d.PredTakenF", i), 32'(bif.PredTakenF), 32'(vecs[i].ept));
            chk($sformatf("v%0d.PredNextF", i), bif.PredNextF, vecs[i].epn);
            chk($sformatf("v%0d.MispredictE", i), 32'(bif.MispredictE), 32'(vecs[i].emp));
            chk($sformatf("v%0d.RecoverPCE", i), bif.RecoverPCE, vecs[i].erc);
            chk($sformatf("v%0d.BranchCount", i), 32'(bif.BranchCount), 32'(vecs[i].ebc));
            chk($sformatf("v%0d.MispredCount", i), 32'(bif.MispredCount), 32'(vecs[i].emc));
            @(posedge clk);
            #1;
        end
        // every update here mispredicts, so both counters must pin at all-ones
        drive('h140, 1'b1, 1'b1, 'h400, 'h800, 'h0, 1'b0, 1'b0);
        repeat (65537) @(posedge clk);
        #1 drive('h400, 1'b0, 1'b0, 'h0, 'h0, 'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sat.BranchCount", 32'(bif.BranchCount), 32'h0000FFFF);
        chk("sat.MispredCount", 32'(bif.MispredCount), 32'h0000FFFF);
        chk("sat.PredNextF", bif.PredNextF, 32'h800);
        @(posedge clk);
        #1 rst = 1'b1;
        drive('h400, 1'b1, 1'b1, 'h500, 'h900, 'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive('h400, 1'b0, 1'b0, 'h0, 'h0, 'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst.BranchCount", 32'(bif.BranchCount), 32'h0);
        chk("rst.MispredCount", 32'(bif.MispredCount), 32'h0);
        chk("rst.PredTakenF400", 32'(bif.PredTakenF), 32'h0);
        chk("rst.PredNextF400", bif.PredNextF, 32'h404);
        bif.PCF = 'h500;
        #1;
        chk("rst.PredTakenF500", 32'(bif.PredTakenF), 32'h0);
        chk("rst.PredNextF500", bif.PredNextF, 32'h504);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
